// File: rtl/meas_logger.sv
// meas_logger: decimates I2C measurement strobes into a BRAM ring buffer,
// following each data word with a status word at address 0.
module meas_logger #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DECIM  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] meas_in,
    input  logic              meas_valid,
    input  logic              enable,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              bram_we,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic [7:0]        drop_cnt,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WR_DATA, WR_STAT} state_t;
    state_t state;
    logic [15:0] seq;
    logic [7:0] decim_cnt;
    logic stb, last, wrap_nxt;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [15:0] seq_nxt;
    // address 0 holds the status word, so the ring spans 1..2^ADDR_W-1
    assign stb      = meas_valid && enable;
    assign last     = wr_ptr == '1;
    assign ptr_nxt  = last ? ADDR_W'(1) : wr_ptr + 1'b1;
    assign seq_nxt  = seq + 16'd1;
    assign wrap_nxt = wrapped | last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bram_we   <= 1'b0;
            busy      <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            wr_ptr    <= ADDR_W'(1);
            seq       <= '0;
            decim_cnt <= '0;
            wrapped   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (stb && state != IDLE && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: if (stb) begin
                    if (decim_cnt == 8'(DECIM - 1)) begin
                        decim_cnt <= '0;
                        state     <= WR_DATA;
                        busy      <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= wr_ptr;
                        bram_din  <= {seq, meas_in};
                    end else begin
                        decim_cnt <= decim_cnt + 8'd1;
                    end
                end
                WR_DATA: begin
                    state     <= WR_STAT;
                    wr_ptr    <= ptr_nxt;
                    seq       <= seq_nxt;
                    wrapped   <= wrap_nxt;
                    bram_addr <= '0;
                    bram_din  <= {wrap_nxt, 4'b0, 11'(ptr_nxt), seq_nxt};
                end
                WR_STAT: begin
                    state   <= IDLE;
                    bram_we <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/meas_logger.md
MEAS_LOGGER -- requirements
Module: meas_logger

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: BRAM port-B word-address width.
REQ-002 SHALL have parameter DATA_W, default 16: measurement width, fixed at 16.
REQ-003 SHALL have parameter DECIM, default 1, legal range 1..255: log one of every DECIM accepted samples.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port meas_in, input, 16: measurement word from the I2C master.
REQ-007 SHALL have port meas_valid, input, 1: one-cycle strobe; meas_in is valid in that cycle.
REQ-008 SHALL have port enable, input, 1: logging enable.
REQ-009 SHALL have port bram_addr, output, ADDR_W: port-B word address.
REQ-010 SHALL have port bram_din, output, 32: port-B write data.
REQ-011 SHALL have port bram_we, output, 1: port-B write enable.
REQ-012 SHALL have port wr_ptr, output, ADDR_W: next data address to be written.
REQ-013 SHALL have port wrapped, output, 1: sticky flag, set once the ring has wrapped.
REQ-014 SHALL have port drop_cnt, output, 8: saturating count of strobes lost while busy.
REQ-015 SHALL have port busy, output, 1: high while a write sequence is in progress.

Function
REQ-016 SHALL implement FSM states IDLE, WR_DATA and WR_STAT; all outputs are registered.
REQ-017 In IDLE, SHALL increment decim_cnt on each meas_valid&&enable; on the strobe where decim_cnt==DECIM-1, SHALL latch meas_in, clear decim_cnt and go to WR_DATA.
REQ-018 WR_DATA (one cycle) SHALL drive bram_we=1, bram_addr=wr_ptr, bram_din={seq[15:0], meas[15:0]}, then go to WR_STAT.
REQ-019 On leaving WR_DATA, SHALL advance wr_ptr and seq together.
  - wr_ptr: +1; from 2^ADDR_W-1 it wraps to 1 (address 0 is reserved) and sets wrapped.
  - seq: +1 modulo 2^16.
REQ-020 WR_STAT (one cycle) SHALL drive bram_we=1, bram_addr=0, bram_din={wrapped, 4'b0, wr_ptr[10:0], seq[15:0]}, using the already-advanced values, then return to IDLE.
REQ-021 Latency: strobe accepted at cycle N -> data write at N+1, status write at N+2, next strobe accepted at N+3.
REQ-022 SHALL hold busy=1 in WR_DATA and WR_STAT, and busy=0 in IDLE.
REQ-023 SHALL drive bram_we=0 in IDLE; bram_addr and bram_din hold their last values.
REQ-024 A meas_valid while busy SHALL be discarded: drop_cnt increments, saturating at 255, and decim_cnt is unchanged.
REQ-025 A meas_valid with enable=0 SHALL be ignored and SHALL NOT count as a drop; deasserting enable mid-sequence lets the sequence complete.
REQ-026 A strobe arriving in the WR_STAT cycle SHALL be dropped, not queued.
REQ-027 Once set, wrapped SHALL stay set until rst.

Reset
REQ-028 rst=1 SHALL immediately force the FSM to IDLE, bram_we=0, busy=0, bram_addr=0, bram_din=0, wr_ptr=1, seq=0, decim_cnt=0, wrapped=0, drop_cnt=0.
REQ-029 rst asserted mid-sequence SHALL abort it with no further write; the first sample after release goes to address 1 with seq=0.

Verification
REQ-030 DECIM=1, enable=1, single strobe meas_in=0x1234 at cycle N -> cycle N+1: we=1, addr=1, din=0x00001234; cycle N+2: we=1, addr=0, din=0x00020001; busy high for exactly 2 cycles.
REQ-031 Strobes on consecutive cycles N, N+1, N+2, N+3 -> samples N and N+3 logged; drop_cnt=2.
REQ-032 ADDR_W=3, 8 strobes spaced 4 cycles apart -> data addresses 1..7 then 1; wrapped rises after the 7th write; final status din={1, 0000, ptr=2, seq=8}.
REQ-033 DECIM=3, 6 strobes with values 0..5 -> only values 2 and 5 written, at addresses 1 and 2.
REQ-034 300 strobes while busy -> drop_cnt=255, held there.
REQ-035 rst pulsed in the WR_DATA cycle -> no status write; the next strobe writes address 1 with seq=0, and wrapped and drop_cnt are 0.
